// File: rtl/mem_cycle_ctl_pkg.sv
// rtl/mem_cycle_ctl_pkg.sv - shared types and defaults for the memory-cycle controller
// Purpose: controller state encoding, single-entry request buffer layout and
// default timeout/counter sizing, shared by the controller and its timeout counter.
package cadr_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ACKD  = 2'd2,
        ST_ABORT = 2'd3
    } state_e;

    typedef struct packed {
        logic valid;
        logic is_write;
    } buf_entry_t;

    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/mem_cycle_ctl_if.sv
// rtl/mem_cycle_ctl_if.sv - microcode/bus handshake and MD select bundle
// Purpose: groups the controller's request, bus handshake and MD select signals.
// Ports (slave = controller side):
//   in : rd_req, wr_req, dest_md, src_md, bus_ack, nxm_clr
//   out: bus_req, bus_wr, mdsel, loadmd, memdrive, md_we, stall, nxm
interface mem_cycle_ctl_if;
    logic rd_req;
    logic wr_req;
    logic dest_md;
    logic src_md;
    logic bus_ack;
    logic nxm_clr;
    logic bus_req;
    logic bus_wr;
    logic mdsel;
    logic loadmd;
    logic memdrive;
    logic md_we;
    logic stall;
    logic nxm;

    modport slave (
        input  rd_req, wr_req, dest_md, src_md, bus_ack, nxm_clr,
        output bus_req, bus_wr, mdsel, loadmd, memdrive, md_we, stall, nxm
    );

    modport master (
        output rd_req, wr_req, dest_md, src_md, bus_ack, nxm_clr,
        input  bus_req, bus_wr, mdsel, loadmd, memdrive, md_we, stall, nxm
    );
endinterface

// File: rtl/mem_cycle_ctl_timeout.sv
// rtl/mem_cycle_ctl_timeout.sv - bus cycle timeout counter
// Purpose: counts cycles while enabled and flags the cycle in which the
// TIMEOUT-th enabled cycle is reached.
// Ports: clk, reset_n (async active-low), i_clr (zero count), i_en (count),
//        o_expired (this enabled cycle is the TIMEOUT-th one).
module mem_timeout #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en)  r_cnt <= r_cnt + 1'b1;
    end

    // r_cnt holds the number of completed enabled cycles, so the current
    // cycle is the TIMEOUT-th one when it equals TIMEOUT-1.
    assign o_expired = i_en && (r_cnt == LAST);
endmodule

// File: rtl/mem_cycle_ctl.sv
// rtl/mem_cycle_ctl.sv - memory cycle controller and MD select sequencer
// Purpose: runs bus request/ack cycles for microcode reads/writes with a
// one-entry request buffer, drives the MD selector, stalls microcode on
// conflicts and aborts cycles that time out (sticky nxm).
// Ports: clk, reset_n (async active-low), bus (mem_cycle_ctl_if.slave).
module mem_cycle_ctl
    import cadr_mem_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            reset_n,
    mem_cycle_ctl_if.slave  bus
);
    state_e     r_state, w_next;
    buf_entry_t r_buf, w_buf_next;
    logic       r_cur_wr, w_cur_wr_next;
    logic       r_nxm;
    logic       w_expired;
    logic       w_new_req, w_rd_pend, w_wr_pend, w_md_busy;
    logic       w_stall, w_req_ok, w_dest_ok, w_loadmd, w_set_nxm;

    mem_timeout #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clr     (r_state != ST_REQ),
        .i_en      (r_state == ST_REQ),
        .o_expired (w_expired)
    );

    assign w_new_req = bus.rd_req || bus.wr_req;
    // A read-abort clears MD this cycle, so MD is not yet usable.
    assign w_rd_pend = ((r_state == ST_REQ || r_state == ST_ABORT) && !r_cur_wr)
                     || (r_buf.valid && !r_buf.is_write);
    assign w_wr_pend = (r_state == ST_REQ && r_cur_wr) || (r_buf.valid && r_buf.is_write);
    // MD load port already claimed by a read completion or an abort.
    assign w_md_busy = (r_state == ST_ACKD && !r_cur_wr) || (r_state == ST_ABORT);

    assign w_stall = (w_new_req && r_buf.valid)
                   || ((bus.dest_md || bus.src_md) && w_rd_pend)
                   || (bus.dest_md && (w_wr_pend || w_md_busy));

    // A stalled microcode instruction is re-issued, so none of its ops act now.
    assign w_req_ok  = w_new_req && !w_stall;
    assign w_dest_ok = bus.dest_md && !w_stall;

    always_comb begin
        w_next        = r_state;
        w_buf_next    = r_buf;
        w_cur_wr_next = r_cur_wr;
        case (r_state)
            ST_IDLE: begin
                if (r_buf.valid) begin
                    w_next        = ST_REQ;
                    w_cur_wr_next = r_buf.is_write;
                    w_buf_next    = '0;
                end else if (w_req_ok) begin
                    w_next        = ST_REQ;
                    w_cur_wr_next = bus.wr_req;
                end
            end
            ST_REQ: begin
                if (bus.bus_ack)    w_next = ST_ACKD;
                else if (w_expired) w_next = ST_ABORT;
            end
            ST_ACKD: begin
                if (r_buf.valid) begin
                    w_next        = ST_REQ;
                    w_cur_wr_next = r_buf.is_write;
                    w_buf_next    = '0;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next     = ST_IDLE;
                w_buf_next = '0;
            end
        endcase
        // Accepted requests outside IDLE only occur with the buffer empty.
        if (r_state != ST_IDLE && w_req_ok) begin
            w_buf_next.valid    = 1'b1;
            w_buf_next.is_write = bus.wr_req;
        end
    end

    assign w_set_nxm = (r_state == ST_REQ) && (w_next == ST_ABORT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_buf    <= '0;
            r_cur_wr <= 1'b0;
            r_nxm    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_buf    <= w_buf_next;
            r_cur_wr <= w_cur_wr_next;
            if (w_set_nxm)        r_nxm <= 1'b1;
            else if (bus.nxm_clr) r_nxm <= 1'b0;
        end
    end

    assign w_loadmd     = (r_state == ST_ACKD) && !r_cur_wr;
    assign bus.bus_req  = (r_state == ST_REQ);
    assign bus.bus_wr   = (r_state == ST_REQ) && r_cur_wr;
    assign bus.loadmd   = w_loadmd;
    // dest_md is always stalled in ACKD-read and ABORT, so it never collides with loadmd.
    assign bus.mdsel    = w_dest_ok;
    // All selects low in ABORT: the selector then yields zero for a read abort.
    assign bus.memdrive = !(w_loadmd || w_dest_ok) && (r_state != ST_ABORT);
    assign bus.md_we    = w_loadmd || w_dest_ok || ((r_state == ST_ABORT) && !r_cur_wr);
    assign bus.stall    = w_stall;
    assign bus.nxm      = r_nxm;
endmodule
